dualram_rd_stream: RTL

- Read-side controller for the 64-deep simple dual-port RAM. It drives the RAM's read port (enable, address) and absorbs the RAM's 1-cycle registered read latency.
- Streams a block of words to a downstream valid/ready consumer with full backpressure support and no word loss or duplication.
- Sits between the RAM read port and the compute/DMA consumer. A block is launched by a start pulse carrying base address and length.

---
 rtl/dualram_rd_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dualram_rd_stream.sv
// Read-side streamer for a 64-deep simple dual-port RAM: issues reads, absorbs the 1-cycle RAM latency
// through a 2-entry FIFO and delivers a block over valid/ready. Optional m_last via DUALRAM_RD_LAST_EN.
module dualram_rd_stream #(
  parameter int DATA_WIDITH = 32,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    len,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_enb,
  output logic [ADDR_WIDTH-1:0]  ram_addrb,
  input  logic [DATA_WIDITH-1:0] ram_doutb,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDITH-1:0] m_data
`ifdef DUALRAM_RD_LAST_EN
  ,
  output logic                   m_last
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ZERO} state_t;

  function automatic logic [ADDR_WIDTH:0] sat_len(input logic [ADDR_WIDTH:0] l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic [ADDR_WIDTH:0]     issued;
  logic [ADDR_WIDTH:0]     popped;
  logic                    vld_p1;
  logic [DATA_WIDITH-1:0]  data_p2 [2];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              fcount;
  logic                    pop;
  logic [2:0]              occ;
`ifdef DUALRAM_RD_LAST_EN
  logic                    last_p1;
  logic                    last_p2 [2];
`endif

  assign pop       = m_valid & m_ready;
  assign m_valid   = (fcount != 2'd0);
  assign m_data    = data_p2[rd_ptr];
  assign busy      = (state != IDLE);
  assign ram_addrb = base_q + issued[ADDR_WIDTH-1:0];

  // FIFO entries plus the word in flight from the RAM must never exceed two slots
  assign occ     = {1'b0, fcount} + {2'b00, vld_p1} - {2'b00, pop};
  assign ram_enb = (state == RUN) && (issued < len_q) && (occ < 3'd2);

`ifdef DUALRAM_RD_LAST_EN
  assign m_last = m_valid & last_p2[rd_ptr];
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = (sat_len(len) == '0) ? ZERO : RUN;
      RUN:   if (ram_enb && (issued == len_q - CNT_ONE)) state_nxt = DRAIN;
      DRAIN: if (popped == len_q) begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      ZERO:  begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      popped <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        len_q  <= sat_len(len);
        issued <= '0;
        popped <= '0;
      end else begin
        if (ram_enb) issued <= issued + CNT_ONE;
        if (pop)     popped <= popped + CNT_ONE;
      end
    end
  end

  // p1: RAM read register stage; vld_p1 marks a word arriving on ram_doutb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= ram_enb;
    end
  end

`ifdef DUALRAM_RD_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1    <= 1'b0;
      last_p2[0] <= 1'b0;
      last_p2[1] <= 1'b0;
    end else begin
      last_p1 <= ram_enb && (issued == len_q - CNT_ONE);
      if (vld_p1) last_p2[wr_ptr] <= last_p1;
    end
  end
`endif

  // p2: output FIFO; simultaneous push and pop leave the occupancy unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p2[0] <= '0;
      data_p2[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fcount     <= 2'd0;
    end else begin
      if (vld_p1) begin
        data_p2[wr_ptr] <= ram_doutb;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({vld_p1, pop})
        2'b10:   fcount <= fcount + 2'd1;
        2'b01:   fcount <= fcount - 2'd1;
        default: fcount <= fcount;
      endcase
    end
  end

endmodule
